// File: rtl/exu_alu_core_pkg.sv
// Shared constants for the execution-stage ALU: widths, function codes and FSM encodings.
package exu_alu_core_pkg;

  localparam int ISA_WIDTH       = 32;
  localparam int ALU_FUNC_WIDTH  = 4;
  localparam int ALU_STATE_WIDTH = 2;

  localparam logic [ALU_STATE_WIDTH-1:0] ALU_IDLE = 2'd0;
  localparam logic [ALU_STATE_WIDTH-1:0] ALU_BUSY = 2'd1;
  localparam logic [ALU_STATE_WIDTH-1:0] ALU_DONE = 2'd2;

  // Codes up to LESS_U are frozen; later ones were appended.
  localparam logic [ALU_FUNC_WIDTH-1:0] FUNC_NO_FUNC = 4'd0;
  localparam logic [ALU_FUNC_WIDTH-1:0] FUNC_ADD     = 4'd1;
  localparam logic [ALU_FUNC_WIDTH-1:0] FUNC_SUB     = 4'd2;
  localparam logic [ALU_FUNC_WIDTH-1:0] FUNC_EQ      = 4'd3;
  localparam logic [ALU_FUNC_WIDTH-1:0] FUNC_NE      = 4'd4;
  localparam logic [ALU_FUNC_WIDTH-1:0] FUNC_LESS_U  = 4'd5;
  localparam logic [ALU_FUNC_WIDTH-1:0] FUNC_LESS_S  = 4'd6;
  localparam logic [ALU_FUNC_WIDTH-1:0] FUNC_AND     = 4'd7;
  localparam logic [ALU_FUNC_WIDTH-1:0] FUNC_OR      = 4'd8;
  localparam logic [ALU_FUNC_WIDTH-1:0] FUNC_XOR     = 4'd9;
  localparam logic [ALU_FUNC_WIDTH-1:0] FUNC_SLL     = 4'd10;
  localparam logic [ALU_FUNC_WIDTH-1:0] FUNC_SRL     = 4'd11;
  localparam logic [ALU_FUNC_WIDTH-1:0] FUNC_SRA     = 4'd12;
  localparam logic [ALU_FUNC_WIDTH-1:0] FUNC_MUL     = 4'd13;

endpackage

// File: rtl/exu_alu_core_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits of a*b.
// done/product are combinational on the final iteration so the parent can register them that edge.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_q;
  logic             active_q;

  assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product = acc_d;
  assign done    = active_q && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (abort) begin
      active_q <= 1'b0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/exu_alu_core.sv
// Execution-stage ALU with valid/ready on both sides; single-cycle ops plus optional iterative MUL.
// Define ALU_MUL_EN to enable the multi-cycle MUL; otherwise MUL decodes as an undefined code.
//
// Handshake: a bundle is taken on a rising edge with in_valid && in_ready; a result is handed off
// on a rising edge with out_valid && out_ready. out_valid/alu_result are stable until handoff.
module exu_alu_core
  import exu_alu_core_pkg::*;
#(
  parameter int DATA_WIDTH  = ISA_WIDTH,
  parameter int FUNC_WIDTH  = ALU_FUNC_WIDTH,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      alu_a,
  input  logic [DATA_WIDTH-1:0]      alu_b,
  input  logic [FUNC_WIDTH-1:0]      alu_func,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      alu_result,
  output logic                       busy,
  output logic [ALU_STATE_WIDTH-1:0] dbg_state
);

  logic [ALU_STATE_WIDTH-1:0] state_q, state_d;
  logic [DATA_WIDTH-1:0]      result_q, result_d;
  logic [DATA_WIDTH-1:0]      op_result;
  logic [SHAMT_WIDTH-1:0]     shamt;
  logic                       accept;

  assign in_ready   = !flush && ((state_q == ALU_IDLE) || ((state_q == ALU_DONE) && out_ready));
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == ALU_DONE);
  assign alu_result = result_q;
  assign dbg_state  = state_q;
  assign shamt      = alu_b[SHAMT_WIDTH-1:0];

`ifdef ALU_MUL_EN
  logic                  is_mul;
  logic                  mul_done;
  logic [DATA_WIDTH-1:0] mul_product;

  assign is_mul = (alu_func == FUNC_MUL);
  assign busy   = (state_q == ALU_BUSY);

  alu_mul_iter #(
    .WIDTH(DATA_WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .abort  (flush),
    .start  (accept && is_mul),
    .a      (alu_a),
    .b      (alu_b),
    .done   (mul_done),
    .product(mul_product)
  );
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    op_result = '0;
    case (alu_func)
      FUNC_ADD:    op_result = alu_a + alu_b;
      FUNC_SUB:    op_result = alu_a - alu_b;
      FUNC_EQ:     op_result = DATA_WIDTH'(alu_a == alu_b);
      FUNC_NE:     op_result = DATA_WIDTH'(alu_a != alu_b);
      FUNC_LESS_U: op_result = DATA_WIDTH'(alu_a < alu_b);
      FUNC_LESS_S: op_result = DATA_WIDTH'($signed(alu_a) < $signed(alu_b));
      FUNC_AND:    op_result = alu_a & alu_b;
      FUNC_OR:     op_result = alu_a | alu_b;
      FUNC_XOR:    op_result = alu_a ^ alu_b;
      FUNC_SLL:    op_result = alu_a << shamt;
      FUNC_SRL:    op_result = alu_a >> shamt;
      FUNC_SRA:    op_result = $unsigned($signed(alu_a) >>> shamt);
      default:     op_result = '0;
    endcase
  end

  // Acceptance is only possible from IDLE or DONE, so it also covers the DONE handoff.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    if (flush) begin
      state_d = ALU_IDLE;
    end else begin
      case (state_q)
        ALU_IDLE, ALU_DONE: begin
          if (accept) begin
            state_d  = ALU_DONE;
            result_d = op_result;
`ifdef ALU_MUL_EN
            if (is_mul) begin
              state_d  = ALU_BUSY;
              result_d = result_q;
            end
`endif
          end else if ((state_q == ALU_DONE) && out_ready) begin
            state_d = ALU_IDLE;
          end
        end
        ALU_BUSY: begin
`ifdef ALU_MUL_EN
          if (mul_done) begin
            state_d  = ALU_DONE;
            result_d = mul_product;
          end
`else
          state_d = ALU_IDLE;
`endif
        end
        default: state_d = ALU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ALU_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_exu_alu_core.sv
// Self-checking bench for exu_alu_core: vector table, hand-written corner sequences and random ops
// against a behavioural model. Works with and without ALU_MUL_EN.
module tb_exu_alu_core;
  import exu_alu_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_func;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];
  logic seen_busy = 1'b0;

  typedef struct {
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  always #5 clk = ~clk;

  always @(negedge clk) if (busy) seen_busy = 1'b1;

  exu_alu_core dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_func  (alu_func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_result(alu_result),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: results from the arithmetic definitions of each operation.
  function automatic logic [31:0] model(logic [3:0] f, logic [31:0] a, logic [31:0] b);
    longint unsigned prod;
    int sh;
    sh = int'(b % 32);
    case (f)
      4'd1:  return a + b;
      4'd2:  return a - b;
      4'd3:  return (a == b) ? 32'd1 : 32'd0;
      4'd4:  return (a != b) ? 32'd1 : 32'd0;
      4'd5:  return (a < b) ? 32'd1 : 32'd0;
      4'd6:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd7:  return a & b;
      4'd8:  return a | b;
      4'd9:  return a ^ b;
      4'd10: return a << sh;
      4'd11: return a >> sh;
      4'd12: return 32'(int'(a) >>> sh);
      4'd13: begin
`ifdef ALU_MUL_EN
        prod = longint'(a) * longint'(b);
        return prod[31:0];
`else
        prod = 0;
        return prod[31:0];
`endif
      end
      default: return 32'd0;
    endcase
  endfunction

  // Issues one op, waits for the result, compares against the front of exp_q.
  task automatic run_op(logic [3:0] f, logic [31:0] a, logic [31:0] b, string name);
    int n;
    logic [31:0] e;
    @(negedge clk);
    in_valid = 1'b1;
    alu_func = f;
    alu_a    = a;
    alu_b    = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_a    = $urandom;
    alu_b    = $urandom;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = exp_q.pop_front();
    check({name, " valid"}, {31'd0, out_valid}, 32'd1);
    check(name, alu_result, e);
  endtask

  task automatic go_idle();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vt[16];
    logic stable;
    logic ok;
    logic [3:0]  rf;
    logic [31:0] ra, rb;

    vt[0]  = '{FUNC_LESS_S, 32'hFFFF_FFFF, 32'd1,          32'd1,          "less_s_neg"};
    vt[1]  = '{FUNC_LESS_U, 32'hFFFF_FFFF, 32'd1,          32'd0,          "less_u_big"};
    vt[2]  = '{FUNC_SRA,    32'h8000_0000, 32'd31,         32'hFFFF_FFFF,  "sra_31"};
    vt[3]  = '{FUNC_SLL,    32'h0000_1234, 32'h0000_0000,  32'h0000_1234,  "sll_0"};
    vt[4]  = '{FUNC_SRL,    32'h0000_00F0, 32'h0000_0024,  32'h0000_000F,  "srl_shamt_lsb"};
    vt[5]  = '{FUNC_SLL,    32'h0000_0001, 32'd31,         32'h8000_0000,  "sll_31"};
    vt[6]  = '{FUNC_SRL,    32'h8000_0000, 32'd31,         32'h0000_0001,  "srl_31"};
    vt[7]  = '{FUNC_SRA,    32'h7000_0000, 32'd4,          32'h0700_0000,  "sra_pos"};
    vt[8]  = '{FUNC_EQ,     32'd7,         32'd7,          32'd1,          "eq_same"};
    vt[9]  = '{FUNC_NE,     32'd7,         32'd7,          32'd0,          "ne_same"};
    vt[10] = '{FUNC_AND,    32'h0000_F0F0, 32'h0000_FF00,  32'h0000_F000,  "and"};
    vt[11] = '{FUNC_OR,     32'h0000_F0F0, 32'h0000_FF00,  32'h0000_FFF0,  "or"};
    vt[12] = '{FUNC_XOR,    32'h0000_F0F0, 32'h0000_FF00,  32'h0000_0FF0,  "xor"};
    vt[13] = '{FUNC_NO_FUNC,32'd5,         32'd5,          32'd0,          "no_func"};
    vt[14] = '{4'd15,       32'hDEAD_BEEF, 32'd1,          32'd0,          "undef_code"};
    vt[15] = '{FUNC_SUB,    32'd3,         32'd10,         32'hFFFF_FFF9,  "sub_wrap"};

    // Clock/reset
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_a = '0; alu_b = '0; alu_func = '0;
    repeat (2) @(negedge clk);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst result", alu_result, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;

    // ADD wrap, then back-to-back issue
    @(negedge clk);
    in_valid = 1'b1; alu_func = FUNC_ADD; alu_a = 32'hFFFF_FFFF; alu_b = 32'd1;
    @(posedge clk); #1;
    check("add_wrap valid", {31'd0, out_valid}, 32'd1);
    check("add_wrap result", alu_result, 32'd0);
    alu_a = 32'd2; alu_b = 32'd3;
    @(negedge clk);
    check("b2b in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b valid", {31'd0, out_valid}, 32'd1);
    check("b2b result", alu_result, 32'd5);
    @(posedge clk); #1;
    check("b2b handoff", {31'd0, out_valid}, 32'd0);

    foreach (vt[i]) begin
      exp_q.push_back(vt[i].exp);
      run_op(vt[i].f, vt[i].a, vt[i].b, vt[i].name);
    end
    go_idle();

`ifdef ALU_MUL_EN
    // MUL: 32 busy cycles then result
    @(negedge clk);
    in_valid = 1'b1; alu_func = FUNC_MUL; alu_a = 32'h0000_FFFF; alu_b = 32'h0001_0001;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_a = '0; alu_b = '0;
    ok = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (!busy || in_ready || out_valid) ok = 1'b0;
      @(posedge clk); #1;
    end
    check("mul busy window", {31'd0, ok}, 32'd1);
    check("mul valid", {31'd0, out_valid}, 32'd1);
    check("mul result", alu_result, 32'hFFFF_FFFF);
    check("mul busy drop", {31'd0, busy}, 32'd0);
    go_idle();
`else
    exp_q.push_back(32'd0);
    run_op(FUNC_MUL, 32'h0000_FFFF, 32'h0001_0001, "mul_disabled");
    go_idle();
`endif

    // SUB held under back-pressure
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; alu_func = FUNC_SUB; alu_a = 32'd5; alu_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_a = '0; alu_b = '0;
    stable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (!out_valid || alu_result !== 32'hFFFF_FFFE) stable = 1'b0;
      @(posedge clk); #1;
    end
    check("stall stable", {31'd0, stable}, 32'd1);
    check("stall result", alu_result, 32'hFFFF_FFFE);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall handoff", {31'd0, out_valid}, 32'd0);
    check("stall result hold", alu_result, 32'hFFFF_FFFE);

    // Flush
`ifdef ALU_MUL_EN
    @(negedge clk);
    in_valid = 1'b1; alu_func = FUNC_MUL; alu_a = 32'd3; alu_b = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ok = 1'b1;
    repeat (9) begin
      if (out_valid) ok = 1'b0;
      @(posedge clk); #1;
    end
    @(negedge clk);
    flush = 1'b1;
    check("flush in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush idle", {30'd0, dbg_state}, {30'd0, ALU_IDLE});
    check("flush busy", {31'd0, busy}, 32'd0);
    repeat (40) begin
      if (out_valid) ok = 1'b0;
      @(posedge clk); #1;
    end
    check("flush no valid", {31'd0, ok}, 32'd1);
`else
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; alu_func = FUNC_ADD; alu_a = 32'd9; alu_b = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    check("flush in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush idle", {30'd0, dbg_state}, {30'd0, ALU_IDLE});
    check("flush no valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
`endif
    exp_q.push_back(32'd5);
    run_op(FUNC_ADD, 32'd2, 32'd3, "add_after_flush");
    go_idle();

    // Asynchronous reset between edges
`ifdef ALU_MUL_EN
    @(negedge clk);
    in_valid = 1'b1; alu_func = FUNC_MUL; alu_a = 32'hFFFF; alu_b = 32'hFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
`else
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; alu_func = FUNC_OR; alu_a = 32'h55; alu_b = 32'hA0;
    @(posedge clk); #1;
    in_valid = 1'b0;
`endif
    #3;
    rst = 1'b0;
    #1;
    check("arst valid", {31'd0, out_valid}, 32'd0);
    check("arst result", alu_result, 32'd0);
    check("arst busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(32'd1);
    run_op(FUNC_EQ, 32'd7, 32'd7, "eq_after_rst");
    go_idle();

    // Random ops against the model
    for (int i = 0; i < 60; i++) begin
      rf = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 40));
      exp_q.push_back(model(rf, ra, rb));
      run_op(rf, ra, rb, $sformatf("rand%0d f%0d", i, rf));
    end
    go_idle();

`ifdef ALU_MUL_EN
    check("busy observed", {31'd0, seen_busy}, 32'd1);
`else
    check("busy never", {31'd0, seen_busy}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
